level_to_pulse: RTL and testbench
=================================

Name: level_to_pulse

Overview:
- Converts a slow, asynchronous, bouncy level input (push-button KEY, switch) into a single-clock-cycle pulse.
- Input path: 2-flop synchronizer, then counter debouncer, then registered edge detector.
- Used by the control block to turn brightness and contrast KEY presses into one-cycle increment/decrement strobes.

Parameters:
- ACTIVE_LOW, 1: 1 = level_in asserted when 0 (DE1-SoC KEY); 0 = asserted when 1.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a change. Minimum 1. Default is 10 ms at 50 MHz.
- EDGE_MODE, 0: 0 = pulse on press, 1 = pulse on release, 2 = pulse on both.
- REPEAT_DELAY, 25000000: hold time before auto-repeat starts (optional feature only).
- REPEAT_PERIOD, 5000000: auto-repeat pulse spacing (optional feature only).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- level_in  in  1  raw asynchronous level; polarity set by ACTIVE_LOW.
- pulse_out  out  1  registered one-cycle strobe.
- level_out  out  1  debounced level, always active-high (1 = pressed).

Behaviour:
- Reset:
  - Sync flops reset to the inactive raw value (1 if ACTIVE_LOW, else 0).
  - Debounced state resets to 0 (not pressed). Debounce counter = 0. pulse_out = 0. level_out = 0.
- Synchronizer: sync1 <= level_in; sync2 <= sync1. Normalize sync2 to active-high as sample = sync2 XOR ACTIVE_LOW.
- Debounce counter:
  - Width = $clog2(DEBOUNCE_CYCLES+1).
  - Each edge where sample != stable and count < DEBOUNCE_CYCLES-1: count increments.
  - Edge where sample != stable and count == DEBOUNCE_CYCLES-1: stable <= sample; count <= 0.
  - Any edge where sample == stable: count <= 0, so a glitch shorter than DEBOUNCE_CYCLES is fully rejected.
  - The counter saturates by construction and never wraps.
- level_out = stable, registered.
- Edge detect: pulse_out <= 1 on the same edge stable flips, qualified by EDGE_MODE; otherwise pulse_out <= 0.
  - 0→1 flip pulses when EDGE_MODE is 0 or 2.
  - 1→0 flip pulses when EDGE_MODE is 1 or 2.
- pulse_out is high for exactly one cycle per accepted transition. No pulse while the input is held, without the optional feature.
- Latency: if the raw change is captured by sync1 at edge k, stable and level_out change and pulse_out rises at edge k+1+DEBOUNCE_CYCLES. pulse_out falls at the next edge.
- Simultaneous events: a mismatch and a counter match-reset cannot coincide; the comparison uses the pre-edge stable value.
- Reset mid-operation:
  - All state clears immediately (asynchronous).
  - If the input is still held active when reset releases, it is treated as a fresh press: a press pulse follows after the normal latency.
  - No pulse is generated during reset.

Optional Feature:
- Macro: L2P_AUTO_REPEAT_EN.
- When defined, while stable == 1 and EDGE_MODE != 1:
  - A hold counter starts at the press pulse.
  - After REPEAT_DELAY cycles, one extra pulse is issued.
  - Further pulses follow every REPEAT_PERIOD cycles until release.
- Release clears the hold counter. A release pulse is still issued in EDGE_MODE 2.
- Repeat pulses are one cycle wide, and a repeat pulse never coincides with a press pulse.
- When undefined: exactly one pulse per accepted transition, and no hold counter logic is synthesized.

Test Plan:
- Reset: rst=1 with level_in=0 (ACTIVE_LOW=1) -> pulse_out=0 and level_out=0 during reset. After release, press pulse at edge 1+DEBOUNCE_CYCLES.
- Clean press: DEBOUNCE_CYCLES=4, ACTIVE_LOW=1; level_in 1→0 captured at edge 0 -> level_out=1 and pulse_out=1 after edge 5, pulse_out=0 after edge 6. Hold for 100 cycles -> no further pulses.
- Bounce rejection: DEBOUNCE_CYCLES=4; toggle level_in 1→0→1 with 3-cycle-wide lows, then hold low -> exactly one pulse, 5 edges after the final stable low is captured.
- Release / EDGE_MODE: EDGE_MODE=2, press then release -> two pulses, one per flip. EDGE_MODE=1 -> pulse only on release.
- Polarity: ACTIVE_LOW=0, level_in 0→1 -> press pulse with the same latency as the ACTIVE_LOW=1 case.
- Auto-repeat (macro defined): DEBOUNCE_CYCLES=2, REPEAT_DELAY=10, REPEAT_PERIOD=5, hold for 30 cycles -> pulses at press, press+10, press+15, press+20, press+25; none after release.

Source files
------------

// File: rtl/level_to_pulse.sv
// level_to_pulse: 2-flop synchronizer -> counter debouncer -> registered edge detector.
// Latency: a raw change captured by sync1 at edge k moves level_out and pulse_out at edge k+1+DEBOUNCE_CYCLES.
// Optional auto-repeat while held is enabled by defining L2P_AUTO_REPEAT_EN; no backpressure (free-running strobe).
module level_to_pulse #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic pulse_out,
  output logic level_out
);

  // Elaboration-time sanity checks on the configuration.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("level_to_pulse: DEBOUNCE_CYCLES must be >= 1");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
    $error("level_to_pulse: EDGE_MODE must be 0, 1 or 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("level_to_pulse: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RAW_IDLE = (ACTIVE_LOW != 0);
  localparam logic             PRESS_EN = (EDGE_MODE == 0) || (EDGE_MODE == 2);
  localparam logic             REL_EN   = (EDGE_MODE == 1) || (EDGE_MODE == 2);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             sample, mismatch, flip, edge_pulse;

  // Debounce decision: a flip happens only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    sample     = sync2_q ^ RAW_IDLE;
    mismatch   = (sample != stable_q);
    flip       = mismatch && (cnt_q == CNT_MAX);
    stable_d   = flip ? sample : stable_q;
    // Any matching sample (or the accepting flip) restarts the count, so short glitches vanish.
    cnt_d      = (mismatch && !flip) ? (cnt_q + CNT_W'(1)) : '0;
    edge_pulse = flip && ((sample && PRESS_EN) || (!sample && REL_EN));
  end

`ifdef L2P_AUTO_REPEAT_EN
  localparam int               HOLD_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               HOLD_W    = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] DELAY_LD  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LD = HOLD_W'(REPEAT_PERIOD - 1);
  localparam logic             REPEAT_EN = (EDGE_MODE != 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rep_pulse;

  // Hold countdown: loaded at the press flip, fires when it reaches zero, then reloads with the period.
  // Repeat pulses need stable_q already 1 and no flip this edge, so they never overlap a press or release.
  always_comb begin
    hold_d    = '0;
    rep_pulse = 1'b0;
    if (REPEAT_EN) begin
      if (flip && sample) begin
        hold_d = DELAY_LD;
      end else if (stable_q && !flip) begin
        if (hold_q == '0) begin
          rep_pulse = 1'b1;
          hold_d    = PERIOD_LD;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
    end
    pulse_d = edge_pulse | rep_pulse;
  end

  // Hold counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Without auto-repeat the strobe is purely the qualified edge.
  always_comb begin
    pulse_d = edge_pulse;
  end
`endif

  // Synchronizer, debouncer and strobe registers; sync flops reset to the idle raw level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= RAW_IDLE;
      sync2_q  <= RAW_IDLE;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= level_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level_out = stable_q;
  assign pulse_out = pulse_q;

endmodule

// File: tb/tb_level_to_pulse.sv
// Directed bench for level_to_pulse: five instances with different polarity / debounce / edge modes
// share one "pressed" stimulus; pulses are logged by edge index relative to a marker and compared
// against hand-computed counts and positions.
module tb_level_to_pulse;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic press = 1'b0;
  logic lvl_al, lvl_ah;
  logic [4:0] pulse_w, level_w;

  assign lvl_al = ~press;
  assign lvl_ah = press;

  always #5 clk = ~clk;

  // u0: active-low, D=4, press only
  level_to_pulse #(.ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5))
    u0 (.clk(clk), .rst(rst), .level_in(lvl_al), .pulse_out(pulse_w[0]), .level_out(level_w[0]));
  // u1: active-low, D=4, both edges
  level_to_pulse #(.ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .REPEAT_DELAY(10), .REPEAT_PERIOD(5))
    u1 (.clk(clk), .rst(rst), .level_in(lvl_al), .pulse_out(pulse_w[1]), .level_out(level_w[1]));
  // u2: active-low, D=4, release only
  level_to_pulse #(.ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5))
    u2 (.clk(clk), .rst(rst), .level_in(lvl_al), .pulse_out(pulse_w[2]), .level_out(level_w[2]));
  // u3: active-high, D=4, press only
  level_to_pulse #(.ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5))
    u3 (.clk(clk), .rst(rst), .level_in(lvl_ah), .pulse_out(pulse_w[3]), .level_out(level_w[3]));
  // u4: active-low, minimum debounce D=1, both edges
  level_to_pulse #(.ACTIVE_LOW(1), .DEBOUNCE_CYCLES(1), .EDGE_MODE(2), .REPEAT_DELAY(10), .REPEAT_PERIOD(5))
    u4 (.clk(clk), .rst(rst), .level_in(lvl_al), .pulse_out(pulse_w[4]), .level_out(level_w[4]));

  int checks   = 0;
  int failures = 0;
  int tick_n   = 0;
  int mark     = 0;
  int pcnt[5];
  int pfirst[5];
  int plast[5];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs sampled 1 time unit after the edge and logged by edge index.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      if (pulse_w[k]) begin
        pcnt[k]++;
        if (pfirst[k] < 0) pfirst[k] = tick_n - mark;
        plast[k] = tick_n - mark;
      end
    end
    tick_n++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mark_start();
    mark = tick_n;
    for (int k = 0; k < 5; k++) begin
      pcnt[k]   = 0;
      pfirst[k] = -1;
      plast[k]  = -1;
    end
  endtask

  task automatic expect_win(input string tag, input int k, input int cnt, input int first, input int last);
    check($sformatf("%s_u%0d_count", tag, k), pcnt[k], cnt);
    check($sformatf("%s_u%0d_first", tag, k), pfirst[k], first);
    check($sformatf("%s_u%0d_last", tag, k), plast[k], last);
  endtask

  initial begin
    // Reset held with the key already pressed: nothing may come out.
    rst   = 1'b1;
    press = 1'b1;
    mark_start();
    ticks(3);
    check("rst_pulse", int'(pulse_w), 0);
    check("rst_level", int'(level_w), 0);
    check("rst_pulse_seen", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4], 0);

    // Release reset with key held: fresh press, pulse at edge 1+D.
    rst = 1'b0;
    mark_start();
    ticks(20);
    expect_win("press", 0, 1, 5, 5);
    expect_win("press", 1, 1, 5, 5);
    expect_win("press", 2, 0, -1, -1);
    expect_win("press", 3, 1, 5, 5);
    expect_win("press", 4, 1, 2, 2);
    check("press_level", int'(level_w), 31);

    // Long hold: no further pulses.
    mark_start();
    ticks(100);
    for (int k = 0; k < 5; k++) check($sformatf("hold_u%0d_count", k), pcnt[k], 0);
    check("hold_level", int'(level_w), 31);

    // Release.
    press = 1'b0;
    mark_start();
    ticks(20);
    expect_win("rel", 0, 0, -1, -1);
    expect_win("rel", 1, 1, 5, 5);
    expect_win("rel", 2, 1, 5, 5);
    expect_win("rel", 3, 0, -1, -1);
    expect_win("rel", 4, 1, 2, 2);
    check("rel_level", int'(level_w), 0);

    // Active pulse exactly D cycles wide is accepted; release follows 4 edges later.
    mark_start();
    press = 1'b1;
    ticks(4);
    press = 1'b0;
    ticks(30);
    expect_win("exactD", 0, 1, 5, 5);
    expect_win("exactD", 1, 2, 5, 9);
    expect_win("exactD", 2, 1, 9, 9);
    expect_win("exactD", 3, 1, 5, 5);
    expect_win("exactD", 4, 2, 2, 6);
    check("exactD_level", int'(level_w), 0);

    // Bounce: two 3-cycle actives (rejected at D=4), then a steady press captured at edge 12.
    mark_start();
    press = 1'b1; ticks(3);
    press = 1'b0; ticks(3);
    press = 1'b1; ticks(3);
    press = 1'b0; ticks(3);
    press = 1'b1; ticks(30);
    expect_win("bounce", 0, 1, 17, 17);
    expect_win("bounce", 1, 1, 17, 17);
    expect_win("bounce", 2, 0, -1, -1);
    expect_win("bounce", 3, 1, 17, 17);
    expect_win("bounce", 4, 5, 2, 14);
    check("bounce_level", int'(level_w), 31);

    // Reset mid-hold: state clears at once, then the held key is a fresh press.
    rst = 1'b1;
    mark_start();
    ticks(2);
    check("midrst_level", int'(level_w), 0);
    check("midrst_pulse_seen", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4], 0);
    rst = 1'b0;
    mark_start();
    ticks(20);
    expect_win("repress", 0, 1, 5, 5);
    expect_win("repress", 2, 0, -1, -1);
    expect_win("repress", 3, 1, 5, 5);
    expect_win("repress", 4, 1, 2, 2);
    check("repress_level", int'(level_w), 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
